// File: rtl/load_store_unit_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification helpers for the load/store unit.
package load_store_unit_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_t;

   function automatic logic op_is_load(input logic [5:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_legal(input logic [5:0] op);
      case (op)
         OP_SB, OP_SH, OP_SW: return 1'b1;
         default:             return op_is_load(op);
      endcase
   endfunction

   function automatic logic op_is_rmw(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH);
   endfunction

   function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] off);
      case (op)
         OP_LH, OP_LHU, OP_SH: return off[0];
         OP_LW, OP_SW:         return off != 2'b00;
         default:              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus word-addressed memory port of the load/store unit.
interface load_store_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_opcode;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [5:0]  mem_opcode;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_read_data;

   modport slave (
      input  req_valid, req_opcode, req_addr, req_wdata, resp_ready, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_address, mem_write_data, mem_opcode, mem_read, mem_write
   );

   modport master (
      output req_valid, req_opcode, req_addr, req_wdata, resp_ready, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_address, mem_write_data, mem_opcode, mem_read, mem_write
   );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: extends the addressed byte/halfword for loads, merges store data into a word.
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [5:0]  op_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
      case (op_i)
         OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_o = {24'd0, byte_sel};
         OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_o = {16'd0, half_sel};
         OP_LW:   load_o = word_i;
         default: load_o = 32'd0;
      endcase
   end

   // Lane 0 is bits 7:0; untouched lanes keep the word read back in RD.
   always_comb begin
      store_o = word_i;
      case (op_i)
         OP_SB:   store_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
         OP_SH:   store_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         OP_SW:   store_o = wdata_i;
         default: store_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, RD/WR one cycle each, sub-word stores as read-modify-write.
// Response held in RESP until resp_ready; requests are only accepted in IDLE.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int MEM_DEPTH = 64,
   parameter int IDX_W     = 6
) (
   input logic               clk,
   input logic               rst_n,
   load_store_unit_if.slave  bus
);

   lsu_state_t       state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [1:0]       off_q, off_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      word_q, word_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             accept;
   logic             req_err;
   logic [31:0]      align_word;
   logic [31:0]      load_val;
   logic [31:0]      store_val;

   assign accept  = bus.req_valid && (state_q == ST_IDLE);
   assign req_err = !op_is_legal(bus.req_opcode)
                 || ((bus.req_addr >> (IDX_W + 2)) != 32'd0)
                 || op_misaligned(bus.req_opcode, bus.req_addr[1:0]);

   // In RD the load result is taken straight from memory so it is ready as RESP begins.
   assign align_word = (state_q == ST_RD) ? bus.mem_read_data : word_q;

   lsu_lane_align u_align (
      .word_i  (align_word),
      .off_i   (off_q),
      .op_i    (op_q),
      .wdata_i (wdata_q),
      .load_o  (load_val),
      .store_o (store_val)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_err)                          state_d = ST_RESP;
               else if (bus.req_opcode == OP_SW)     state_d = ST_WR;
               else                                  state_d = ST_RD;
            end
         end
         ST_RD:   state_d = op_is_rmw(op_q) ? ST_WR : ST_RESP;
         ST_WR:   state_d = ST_RESP;
         ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready      = (state_q == ST_IDLE);
      bus.resp_valid     = (state_q == ST_RESP);
      bus.resp_rdata     = rdata_q;
      bus.resp_err       = err_q;
      bus.mem_read       = (state_q == ST_RD);
      bus.mem_write      = (state_q == ST_WR);
      bus.mem_opcode     = OP_SW;
      bus.mem_address    = 32'd0;
      bus.mem_write_data = 32'd0;
      if ((state_q == ST_RD) || (state_q == ST_WR)) begin
         bus.mem_address = {{(32 - IDX_W){1'b0}}, idx_q};
      end
      if (state_q == ST_WR) begin
         bus.mem_write_data = store_val;
      end
   end

   always_comb begin
      op_d    = op_q;
      off_d   = off_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (accept) begin
         op_d    = bus.req_opcode;
         off_d   = bus.req_addr[1:0];
         idx_d   = bus.req_addr[IDX_W+1:2];
         wdata_d = bus.req_wdata;
         rdata_d = 32'd0;
         err_d   = req_err;
      end
      if (state_q == ST_RD) begin
         word_d = bus.mem_read_data;
         if (op_is_load(op_q)) rdata_d = load_val;
      end
      if ((state_q == ST_RESP) && bus.resp_ready) begin
         rdata_d = 32'd0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= 6'd0;
         off_q   <= 2'd0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         word_q  <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         op_q    <= op_d;
         off_q   <= off_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word memory model and strobe counters.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic clk;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   int   rd_cnt = 0;
   int   wr_cnt = 0;
   logic [31:0] last_wdata = 32'd0;
   logic [31:0] last_waddr = 32'd0;
   logic [31:0] last_raddr = 32'd0;
   logic [31:0] mem [64];

   load_store_unit_if bus ();

   load_store_unit #(.MEM_DEPTH(64), .IDX_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_read_data = mem[bus.mem_address[5:0]];

   always @(posedge clk) begin
      if (bus.mem_write) begin
         mem[bus.mem_address[5:0]] <= bus.mem_write_data;
         last_wdata <= bus.mem_write_data;
         last_waddr <= bus.mem_address;
         wr_cnt     <= wr_cnt + 1;
      end
      if (bus.mem_read) begin
         last_raddr <= bus.mem_address;
         rd_cnt     <= rd_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_rd, input int exp_wr, input int stall);
      int rd0;
      int wr0;
      int lat;
      logic [31:0] held;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      @(negedge clk);
      check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_opcode = op;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         @(negedge clk);
         if (bus.resp_valid) lat = k;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, bus.resp_rdata, exp_rdata);
      check({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
      held = bus.resp_rdata;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check({tag, " stall resp_valid"}, 32'(bus.resp_valid), 32'd1);
         check({tag, " stall req_ready"}, 32'(bus.req_ready), 32'd0);
         check({tag, " stall rdata"}, bus.resp_rdata, held);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      @(negedge clk);
      check({tag, " idle resp_valid"}, 32'(bus.resp_valid), 32'd0);
      check({tag, " idle rdata"}, bus.resp_rdata, 32'd0);
      check({tag, " reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
      check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_opcode = 6'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.resp_ready = 1'b0;
      #12;
      check("rst req_ready", 32'(bus.req_ready), 32'd1);
      check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst resp_rdata", bus.resp_rdata, 32'd0);
      check("rst resp_err", 32'(bus.resp_err), 32'd0);
      check("rst mem_read", 32'(bus.mem_read), 32'd0);
      check("rst mem_write", 32'(bus.mem_write), 32'd0);
      check("rst mem_address", bus.mem_address, 32'd0);
      check("rst mem_write_data", bus.mem_write_data, 32'd0);
      check("rst mem_opcode", 32'(bus.mem_opcode), 32'h2B);
      @(negedge clk);
      rst_n = 1'b1;

      run("sw w5", OP_SW, 32'h14, 32'h8899AABB, 2, 32'd0, 1'b0, 0, 1, 0);
      check("sw w5 wdata", last_wdata, 32'h8899AABB);
      check("sw w5 waddr", last_waddr, 32'd5);
      run("lb 15", OP_LB, 32'h15, 32'd0, 2, 32'hFFFFFFAA, 1'b0, 1, 0, 0);
      check("lb 15 raddr", last_raddr, 32'd5);
      run("lbu 15", OP_LBU, 32'h15, 32'd0, 2, 32'h000000AA, 1'b0, 1, 0, 0);
      run("lw 14", OP_LW, 32'h14, 32'd0, 2, 32'h8899AABB, 1'b0, 1, 0, 0);

      run("sw w3", OP_SW, 32'h0C, 32'h11223344, 2, 32'd0, 1'b0, 0, 1, 0);
      run("sb 0E", OP_SB, 32'h0E, 32'h000000EE, 3, 32'd0, 1'b0, 1, 1, 0);
      check("sb 0E wdata", last_wdata, 32'h11EE3344);
      check("sb 0E waddr", last_waddr, 32'd3);
      run("lw 0C", OP_LW, 32'h0C, 32'd0, 2, 32'h11EE3344, 1'b0, 1, 0, 0);

      run("sw w4", OP_SW, 32'h10, 32'h00000000, 2, 32'd0, 1'b0, 0, 1, 0);
      run("sh 12", OP_SH, 32'h12, 32'h0000CAFE, 3, 32'd0, 1'b0, 1, 1, 0);
      check("sh 12 wdata", last_wdata, 32'hCAFE0000);
      run("lh 12", OP_LH, 32'h12, 32'd0, 2, 32'hFFFFCAFE, 1'b0, 1, 0, 0);
      run("lhu 12", OP_LHU, 32'h12, 32'd0, 2, 32'h0000CAFE, 1'b0, 1, 0, 0);
      run("lb 13", OP_LB, 32'h13, 32'd0, 2, 32'hFFFFFFCA, 1'b0, 1, 0, 0);

      run("err lw 06", OP_LW, 32'h06, 32'd0, 1, 32'd0, 1'b1, 0, 0, 0);
      run("err sh 01", OP_SH, 32'h01, 32'h1234, 1, 32'd0, 1'b1, 0, 0, 0);
      run("err lw 100", OP_LW, 32'h100, 32'd0, 1, 32'd0, 1'b1, 0, 0, 0);
      run("err op 00", 6'h00, 32'h00, 32'd0, 1, 32'd0, 1'b1, 0, 0, 0);
      run("lw FC", OP_LW, 32'hFC, 32'd0, 2, mem[63], 1'b0, 1, 0, 0);

      run("sw stall", OP_SW, 32'h08, 32'hDEADBEEF, 2, 32'd0, 1'b0, 0, 1, 4);
      check("sw stall wdata", last_wdata, 32'hDEADBEEF);
      run("lw 08", OP_LW, 32'h08, 32'd0, 2, 32'hDEADBEEF, 1'b0, 1, 0, 0);

      wr0 = wr_cnt;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_opcode = OP_SB;
      bus.req_addr   = 32'h20;
      bus.req_wdata  = 32'h000000EE;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check("mid rst RD mem_read", 32'(bus.mem_read), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid rst mem_read", 32'(bus.mem_read), 32'd0);
      check("mid rst mem_write", 32'(bus.mem_write), 32'd0);
      check("mid rst req_ready", 32'(bus.req_ready), 32'd1);
      check("mid rst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("mid rst mem_address", bus.mem_address, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("mid rst writes", 32'(wr_cnt - wr0), 32'd0);
      run("lw after rst", OP_LW, 32'h14, 32'd0, 2, 32'h8899AABB, 1'b0, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the word-addressed data memory.
- Accepts one load/store request at a time and checks alignment and range.
- Runs byte/halfword stores as read-modify-write with full-word memory writes.
- Sign- or zero-extends load data and returns it through a valid/ready response handshake.

Parameters:
MEM_DEPTH, 64, number of 32-bit words in the data memory; word index range 0..MEM_DEPTH-1
IDX_W, 6, width of the word index driven to memory (clog2 of MEM_DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_opcode  input  6  lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B
req_addr  input  32  byte address from the ALU
req_wdata  input  32  store data (rt)
resp_valid  output  1  response present
resp_ready  input  1  consumer takes the response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, out-of-range or illegal opcode
mem_address  output  32  word index, zero-extended to 32 bits
mem_write_data  output  32  full word to write
mem_opcode  output  6  constant 0x2B, so memory always does full-word writes
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_read_data  input  32  combinational read data from memory

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - State IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
  - Captured request registers cleared.
- States: IDLE, RD, WR, RESP.
  - req_ready=1 only in IDLE.
  - Acceptance is the edge where req_valid && req_ready. That edge latches opcode, byte offset addr[1:0], word index addr[IDX_W+1:2] and wdata.
- Error check at acceptance, in priority order:
  1. Illegal opcode.
  2. Out of range: addr[31:IDX_W+2] != 0.
  3. Misaligned: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0.
  - On error: next state RESP, resp_err=1, resp_rdata=0. No memory strobe is ever issued.
- Transitions after acceptance:
  - Loads: IDLE -> RD -> RESP.
  - sw: IDLE -> WR -> RESP.
  - sb/sh: IDLE -> RD -> WR -> RESP.
- RD (exactly one cycle):
  - mem_read=1, mem_address=word index.
  - mem_read_data is captured into a word register at the edge that leaves RD.
- WR (exactly one cycle):
  - mem_write=1, mem_address=word index.
  - sw: mem_write_data = wdata.
  - sb: the captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - sh: the captured word with halfword lane addr[1] replaced by wdata[15:0].
  - Lane 0 = bits 7:0 (little-endian lanes).
- Load extraction: select the byte/halfword lane by offset. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stay stable until resp_valid && resp_ready.
  - On that edge: next state IDLE, resp_valid=0, resp_rdata/resp_err cleared.
  - Stores return resp_rdata=0.
- Latency from acceptance edge to resp_valid high:
  - Error: 1 cycle.
  - lw/lb/lbu/lh/lhu and sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Back-to-back throughput: one request per (latency+1) cycles minimum.
- Strobes:
  - mem_read and mem_write are never high together.
  - Each is high for exactly one cycle per access.
  - mem_opcode is always 0x2B.
- Memory write occurs only in WR; a response stall in RESP never repeats the write.
- Reset mid-operation: all state is dropped immediately. Any pending response or partial RMW is discarded; the write occurs only if WR had already been sampled by a clock edge.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package holds:
  - Opcode localparams OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW.
  - State encoding lsu_state_t.
- One natural combinational sub-module, lsu_lane_align: inputs word, offset, opcode, store data; outputs the extended load value and the merged store word. The top holds the FSM and registers.

Test Plan:
- Memory word 5 = 0x8899AABB; lb at addr 0x15 -> mem_read one cycle at index 5, resp_rdata=0xFFFFFFAA after 2 cycles; lbu -> 0x000000AA.
- Word 3 = 0x11223344; sb wdata=0xEE addr 0x0E -> RD then WR, mem_write_data=0x11EE3344, resp_valid at cycle 3, resp_rdata=0.
- sh wdata=0xCAFE addr 0x12 onto 0x00000000 -> mem_write_data=0xCAFE0000; then lh 0x12 -> 0xFFFFCAFE, lhu 0x12 -> 0x0000CAFE.
- lw addr 0x06, sh addr 0x01, lw addr 0x100 (index 64), opcode 0x00 -> resp_err=1 after 1 cycle, resp_rdata=0, no mem_read/mem_write pulse.
- sw 0xDEADBEEF addr 0x08 with resp_ready held low 4 cycles -> exactly one mem_write, resp_valid stays high with stable data, req_ready=0 until resp_ready.
- rst_n asserted during RD of an sb -> outputs take reset values immediately, no mem_write; a new lw is accepted after reset release.
